// File: rtl/bnn_cmd_sequencer_if.sv
// Byte-level bus between SPI byte receiver/transmitter, BNN core and the command sequencer.
// The master modport is the sequencer side; the slave modport is the SPI/core side.
interface bnn_cmd_sequencer_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [3:0]        sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              start;
    logic              core_done;
    logic [7:0]        core_result;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              err;

    modport master (
        input  rx_data, rx_valid, core_done, core_result, tx_ready,
        output rx_ready, sel, wr_en, wr_addr, wr_data, start, tx_data, tx_valid, err
    );

    modport slave (
        output rx_data, rx_valid, core_done, core_result, tx_ready,
        input  rx_ready, sel, wr_en, wr_addr, wr_data, start, tx_data, tx_valid, err
    );
endinterface

// File: rtl/bnn_cmd_sequencer.sv
// Command sequencer: decodes SPI command bytes, steers payload into the BNN register
// banks, launches inference and hands the result byte back to the SPI transmitter.
// Optional LOAD inter-byte timeout enabled by defining BNN_SEQ_TIMEOUT_EN.
module bnn_cmd_sequencer #(
    parameter int unsigned N_IN_BYTES  = 2,
    parameter int unsigned N_W_BYTES   = 2,
    parameter int unsigned N_B_BYTES   = 2,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    bnn_cmd_sequencer_if.master   bus
);
    localparam int unsigned NMax01 = (N_IN_BYTES > N_W_BYTES) ? N_IN_BYTES : N_W_BYTES;
    localparam int unsigned NMax   = (NMax01 > N_B_BYTES) ? NMax01 : N_B_BYTES;
    localparam logic [ADDR_W:0] LimIn = (ADDR_W+1)'(N_IN_BYTES);
    localparam logic [ADDR_W:0] LimW  = (ADDR_W+1)'(N_W_BYTES);
    localparam logic [ADDR_W:0] LimB  = (ADDR_W+1)'(N_B_BYTES);

    if ((2 ** ADDR_W) < NMax) begin : g_addr_w_check
        $error("ADDR_W too narrow for the largest payload");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StReply} state_e;

    state_e            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              start_q, start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   limit_q, limit_d;
    logic [ADDR_W:0]   cnt_inc;
    logic              rx_ready;
    logic              accept;

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    // Accept bytes only while idle or loading; held low while reset is asserted.
    assign rx_ready = ~rst & ((state_q == StIdle) | (state_q == StLoad));
    assign accept   = bus.rx_valid & rx_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        limit_d    = limit_q;
`ifdef BNN_SEQ_TIMEOUT_EN
        timer_d    = '0;
`endif
        unique case (state_q)
            StIdle: begin
                // sel covers the final write of a load, then drops here
                sel_d = 4'b0000;
                if (accept) begin
                    case (bus.rx_data)
                        8'hB1: begin
                            sel_d = 4'b0001; cnt_d = '0; limit_d = LimIn; state_d = StLoad;
                        end
                        8'hB2: begin
                            sel_d = 4'b0010; cnt_d = '0; limit_d = LimW; state_d = StLoad;
                        end
                        8'hB3: begin
                            sel_d = 4'b0100; cnt_d = '0; limit_d = LimB; state_d = StLoad;
                        end
                        8'hAE: begin
                            sel_d = 4'b1000; start_d = 1'b1; state_d = StRun;
                        end
                        8'h00: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StLoad: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.rx_data;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == limit_q) state_d = StIdle;
                end
`ifdef BNN_SEQ_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    sel_d   = 4'b0000;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            StRun: begin
                // start_q marks the first RUN cycle, where core_done is not trusted
                if (!start_q && bus.core_done) begin
                    tx_data_d  = bus.core_result;
                    tx_valid_d = 1'b1;
                    sel_d      = 4'b0000;
                    state_d    = StReply;
                end
            end
            StReply: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            limit_q    <= '0;
`ifdef BNN_SEQ_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            limit_q    <= limit_d;
`ifdef BNN_SEQ_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.sel      = sel_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.start    = start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_bnn_cmd_sequencer.sv
// Directed bench for bnn_cmd_sequencer with write/result scoreboards.
module tb_bnn_cmd_sequencer;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   err_cnt = 0;
    int   start_cnt = 0;

    logic [15:0] wr_q[$];  // {sel, addr, data}
    logic [7:0]  tx_q[$];

    bnn_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    bnn_cmd_sequencer #(
        .N_IN_BYTES (2),
        .N_W_BYTES  (2),
        .N_B_BYTES  (2),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every wr_en cycle must match the oldest pushed write.
    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr", {16'h0, bus.sel, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
            end else begin
                check("wr", {16'h0, bus.sel, bus.wr_addr, bus.wr_data}, {16'h0, wr_q.pop_front()});
            end
        end
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) check("unexpected_tx", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
            else check("tx", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
        end
        if (!rst && bus.err) err_cnt++;
        if (!rst && bus.start) start_cnt++;
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = 8'h00;
        bus.tx_ready    = 1'b0;

        // Reset state
        #12;
        check("rst_outs", {bus.sel, bus.wr_en, bus.start, bus.tx_valid, bus.err, bus.rx_ready},
              32'h0);
        check("rst_data", {bus.wr_addr, bus.wr_data, bus.tx_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", bus.rx_ready, 1);

        // Input load
        wr_q.push_back({4'b0001, 4'd0, 8'h0E});
        wr_q.push_back({4'b0001, 4'd1, 8'hDE});
        send(8'hB1);
        check("sel_inputs", bus.sel, 4'b0001);
        send(8'h0E);
        send(8'hDE);
        idle(3);
        check("sel_back_to_0", bus.sel, 0);
        check("in_writes_done", wr_q.size(), 0);

        // Weights then bias back-to-back
        wr_q.push_back({4'b0010, 4'd0, 8'hDE});
        wr_q.push_back({4'b0010, 4'd1, 8'h00});
        wr_q.push_back({4'b0100, 4'd0, 8'hDE});
        wr_q.push_back({4'b0100, 4'd1, 8'h00});
        send(8'hB2); send(8'hDE); send(8'h00);
        send(8'hB3); send(8'hDE); send(8'h00);
        idle(3);
        check("wb_writes_done", wr_q.size(), 0);
        check("wb_no_err", err_cnt, 0);

        // Bad command, NOP, command codes as payload
        send(8'h5A);
        idle(3);
        check("bad_cmd_err", err_cnt, 1);
        check("bad_cmd_rx_ready", bus.rx_ready, 1);
        send(8'h00);
        idle(3);
        check("nop_no_err", err_cnt, 1);
        wr_q.push_back({4'b0001, 4'd0, 8'hB2});
        wr_q.push_back({4'b0001, 4'd1, 8'hAE});
        send(8'hB1); send(8'hB2); send(8'hAE);
        idle(3);
        check("payload_writes_done", wr_q.size(), 0);
        check("payload_no_start", start_cnt, 0);

        // Run with delayed done and stalled transmitter
        send(8'hAE);
        check("start_pulse", bus.start, 1);
        check("run_rx_ready", bus.rx_ready, 0);
        check("run_sel", bus.sel, 4'b1000);
        idle(10);
        check("start_one_cycle", start_cnt, 1);
        tx_q.push_back(8'h3C);
        bus.core_done   = 1'b1;
        bus.core_result = 8'h3C;
        @(negedge clk);
        bus.core_done   = 1'b0;
        bus.core_result = 8'h00;
        for (int i = 0; i < 3; i++) begin
            check("tx_valid_held", bus.tx_valid, 1);
            check("tx_data_held", bus.tx_data, 8'h3C);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check("tx_done_valid", bus.tx_valid, 0);
        check("tx_done_rx_ready", bus.rx_ready, 1);
        check("tx_popped", tx_q.size(), 0);

        // done during the start cycle is ignored; tx_ready already high completes at once
        bus.tx_ready = 1'b1;
        send(8'hAE);
        bus.core_done   = 1'b1;
        bus.core_result = 8'h99;
        @(posedge clk);
        #1;
        bus.core_done = 1'b0;
        check("done_in_start_ignored", bus.tx_valid, 0);
        idle(2);
        tx_q.push_back(8'hA5);
        bus.core_done   = 1'b1;
        bus.core_result = 8'hA5;
        @(negedge clk);
        bus.core_done = 1'b0;
        check("reply_first_valid", bus.tx_valid, 1);
        @(negedge clk);
        check("reply_one_cycle", bus.tx_valid, 0);
        check("tx2_popped", tx_q.size(), 0);
        bus.tx_ready = 1'b0;

        // Reset mid-LOAD
        wr_q.push_back({4'b0010, 4'd0, 8'h11});
        send(8'hB2);
        send(8'h11);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midload_rst_outs", {bus.sel, bus.wr_en, bus.start, bus.tx_valid, bus.err,
              bus.rx_ready}, 32'h0);
        check("midload_rst_addr", bus.wr_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        wr_q.push_back({4'b0010, 4'd0, 8'h77});
        wr_q.push_back({4'b0010, 4'd1, 8'h88});
        send(8'hB2); send(8'h77); send(8'h88);
        idle(3);
        check("restart_writes_done", wr_q.size(), 0);

        // Inter-byte stall in LOAD
        wr_q.push_back({4'b0100, 4'd0, 8'h55});
        send(8'hB3);
        send(8'h55);
        idle(20);
`ifdef BNN_SEQ_TIMEOUT_EN
        check("timeout_err", err_cnt, 2);
        check("timeout_sel", bus.sel, 0);
        check("timeout_writes_kept", wr_q.size(), 0);
`else
        check("no_timeout_err", err_cnt, 1);
        check("no_timeout_sel", bus.sel, 4'b0100);
        wr_q.push_back({4'b0100, 4'd1, 8'h66});
        send(8'h66);
        idle(3);
        check("stall_load_done", wr_q.size(), 0);
        check("stall_sel_clear", bus.sel, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
